keypad_encoder: RTL

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_encoder.sv
// Keypad scanner and encoder for a 4x4 matrix keypad.
// Rows are driven low one at a time and the active-low columns are sampled at
// the end of each row slot; a frame of four slots is classified as none,
// single or multi.  A small FSM debounces presses and releases and turns an
// accepted key into a digit strobe or a stretched start/end pulse.
module keypad_encoder #(
    parameter int SCAN_DIV  = 1000,
    parameter int DEBOUNCE  = 4,
    parameter int PULSE_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       ps_start,
    output logic [3:0] ps_num,
    output logic       ps_end,
    output logic       num_strobe,
    output logic [1:0] kp_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DEBOUNCE = 2'b01,
        ST_EMIT     = 2'b10,
        ST_RELEASE  = 2'b11
    } state_t;

    // Number of asserted bits in a 4-bit vector.
    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest asserted bit (only meaningful when exactly one is set).
    function automatic logic [1:0] low_index4(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    // Key code {row, col} to {is_digit, digit}; map 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    function automatic logic [4:0] key_digit(input logic [3:0] code);
        logic [4:0] d;
        case (code)
            4'd0:    d = {1'b1, 4'd1};
            4'd1:    d = {1'b1, 4'd2};
            4'd2:    d = {1'b1, 4'd3};
            4'd4:    d = {1'b1, 4'd4};
            4'd5:    d = {1'b1, 4'd5};
            4'd6:    d = {1'b1, 4'd6};
            4'd8:    d = {1'b1, 4'd7};
            4'd9:    d = {1'b1, 4'd8};
            4'd10:   d = {1'b1, 4'd9};
            4'd13:   d = {1'b1, 4'd0};
            default: d = {1'b0, 4'd0};
        endcase
        return d;
    endfunction

    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;

    logic [3:0]    col_meta_r, col_sync_r;
    logic [DW-1:0] div_cnt_r;
    logic [1:0]    row_idx_r;
    logic [3:0]    row_out_r;
    logic [1:0]    frame_cnt_r;   // 0 none, 1 single, 2 multi (saturating)
    logic [3:0]    frame_key_r;
    state_t        state_r, state_nx_s;
    logic [CW-1:0] match_cnt_r, match_nx_s, match_inc_s;
    logic [3:0]    key_r, key_nx_s;
    logic [3:0]    ps_num_r;
    logic          num_strobe_r, ps_start_r, ps_end_r;
    logic [PW-1:0] pulse_cnt_r;

    logic          slot_end_s, frame_end_s;
    logic [3:0]    row_hits_s;
    logic [2:0]    row_hit_cnt_s, acc_total_s;
    logic [1:0]    acc_cnt_s;
    logic [3:0]    acc_key_s;
    logic          frame_none_s, frame_single_s;
    logic [1:0]    row_nx_s;
    logic [4:0]    digit_s;
    logic          emit_s;

    assign slot_end_s    = (div_cnt_r == DW'(SCAN_DIV - 1));
    assign frame_end_s   = slot_end_s && (row_idx_r == 2'd3);
    assign row_hits_s    = ~col_sync_r;
    assign row_hit_cnt_s = count_ones4(row_hits_s);
    assign row_nx_s      = row_idx_r + 2'd1;
    assign match_inc_s   = match_cnt_r + CW'(1);
    assign digit_s       = key_digit(key_r);
    assign emit_s        = (state_r == ST_EMIT);

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
        end
    end

    // Free-running row scanner: one row slot lasts SCAN_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= '0;
            row_idx_r <= 2'd0;
            row_out_r <= 4'b1110;
        end else if (slot_end_s) begin
            div_cnt_r <= '0;
            row_idx_r <= row_nx_s;
            row_out_r <= ~(4'b0001 << row_nx_s);
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Merge this slot's column sample into the running frame classification.
    always_comb begin
        acc_total_s = {1'b0, frame_cnt_r} + row_hit_cnt_s;
        acc_cnt_s   = frame_cnt_r;
        acc_key_s   = frame_key_r;
        if (acc_total_s >= 3'd2) begin
            acc_cnt_s = 2'd2;
        end else begin
            acc_cnt_s = acc_total_s[1:0];
        end
        if (row_hit_cnt_s == 3'd1) begin
            acc_key_s = {row_idx_r, low_index4(row_hits_s)};
        end else begin
            acc_key_s = frame_key_r;
        end
    end

    assign frame_none_s   = frame_end_s && (acc_cnt_s == 2'd0);
    assign frame_single_s = frame_end_s && (acc_cnt_s == 2'd1);

    // Frame accumulator, cleared when a frame completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 2'd0;
            frame_key_r <= 4'd0;
        end else if (frame_end_s) begin
            frame_cnt_r <= 2'd0;
            frame_key_r <= 4'd0;
        end else if (slot_end_s) begin
            frame_cnt_r <= acc_cnt_s;
            frame_key_r <= acc_key_s;
        end else begin
            frame_cnt_r <= frame_cnt_r;
            frame_key_r <= frame_key_r;
        end
    end

    // Debounce FSM next-state: decisions are taken only at frame boundaries.
    always_comb begin
        state_nx_s = state_r;
        match_nx_s = match_cnt_r;
        key_nx_s   = key_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_single_s) begin
                    key_nx_s   = acc_key_s;
                    match_nx_s = CW'(1);
                    if (CW'(DEBOUNCE) == CW'(1)) begin
                        state_nx_s = ST_EMIT;
                    end else begin
                        state_nx_s = ST_DEBOUNCE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (frame_single_s && (acc_key_s == key_r)) begin
                    match_nx_s = match_inc_s;
                    if (match_inc_s == CW'(DEBOUNCE)) begin
                        state_nx_s = ST_EMIT;
                    end else begin
                        state_nx_s = ST_DEBOUNCE;
                    end
                end else if (frame_end_s) begin
                    state_nx_s = ST_IDLE;
                    match_nx_s = '0;
                end else begin
                    state_nx_s = ST_DEBOUNCE;
                end
            end
            ST_EMIT: begin
                state_nx_s = ST_RELEASE;
                match_nx_s = '0;
            end
            ST_RELEASE: begin
                if (frame_none_s) begin
                    if (match_inc_s == CW'(DEBOUNCE)) begin
                        state_nx_s = ST_IDLE;
                        match_nx_s = '0;
                    end else begin
                        match_nx_s = match_inc_s;
                    end
                end else if (frame_end_s) begin
                    match_nx_s = '0;
                end else begin
                    match_nx_s = match_cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                match_nx_s = '0;
            end
        endcase
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            match_cnt_r <= '0;
            key_r       <= 4'd0;
        end else begin
            state_r     <= state_nx_s;
            match_cnt_r <= match_nx_s;
            key_r       <= key_nx_s;
        end
    end

    // Registered outputs: digit strobe and stretched start/end pulses after EMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_num_r     <= 4'd0;
            num_strobe_r <= 1'b0;
            ps_start_r   <= 1'b0;
            ps_end_r     <= 1'b0;
            pulse_cnt_r  <= '0;
        end else begin
            if (emit_s && digit_s[4]) begin
                ps_num_r     <= digit_s[3:0];
                num_strobe_r <= 1'b1;
            end else begin
                num_strobe_r <= 1'b0;
            end
            if (emit_s && (key_r == KEY_STAR)) begin
                ps_start_r  <= 1'b1;
                ps_end_r    <= 1'b0;
                pulse_cnt_r <= PW'(PULSE_LEN - 1);
            end else if (emit_s && (key_r == KEY_HASH)) begin
                ps_start_r  <= 1'b0;
                ps_end_r    <= 1'b1;
                pulse_cnt_r <= PW'(PULSE_LEN - 1);
            end else if (pulse_cnt_r != '0) begin
                pulse_cnt_r <= pulse_cnt_r - PW'(1);
            end else begin
                ps_start_r <= 1'b0;
                ps_end_r   <= 1'b0;
            end
        end
    end

    assign row_out    = row_out_r;
    assign ps_num     = ps_num_r;
    assign num_strobe = num_strobe_r;
    assign ps_start   = ps_start_r;
    assign ps_end     = ps_end_r;
    assign kp_state   = state_r;

endmodule
